// File: rtl/mtl_timing_ctrl.sv
// mtl_timing_ctrl
//   Timing controller and pixel-fetch scheduler for the 800x480 MTL panel.
//   Generates hsd/vsd/de, issues one pix_req per active pixel FETCH_LAT
//   clocks ahead of the data slot, and substitutes bg_color (flagging a
//   sticky underflow) when upstream data is late.
//
// Ports
//   clk, reset            pixel clock, asynchronous active-high reset
//   enable                run request; an idle block starts a frame, a
//                         running block stops only at the end of a frame
//   bg_color[23:0]        {R,G,B} used when pix_valid is missing
//   clr_underflow         clears underflow (a same-cycle set wins)
//   pix_req               read strobe to the frame buffer
//   pix_data[23:0]        {R,G,B} returned FETCH_LAT clocks after pix_req
//   pix_valid             qualifies pix_data in its expected slot only
//   hsd, vsd              active-low panel syncs
//   de, rgb[23:0]         data enable and pixel; rgb is 0 outside de
//   x[10:0], y[9:0]       active coordinates, 0 outside de
//   frame_start           one-cycle pulse with the first sync of a frame
//   underflow             sticky late-data flag
//
// State table
//   IDLE | counters held at (0,0), no requests, syncs inactive
//   RUN  | raster counters advance; exit only at the last position of a frame
module mtl_timing_ctrl #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 210,
  parameter int H_SYNC    = 30,
  parameter int H_BP      = 16,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 22,
  parameter int V_SYNC    = 13,
  parameter int V_BP      = 10,
  parameter int FETCH_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] bg_color,
  input  logic        clr_underflow,
  output logic        pix_req,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        hsd,
  output logic        vsd,
  output logic        de,
  output logic [23:0] rgb,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [10:0] x;
    logic [9:0]  y;
  } stage_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  stage_t        st_nxt;
  stage_t        pipe [0:FETCH_LAT];
  logic          run_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          if (v_cnt == V_LAST) begin
            v_nxt = '0;
            if (!enable) state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + 1'b1;
          end
        end else begin
          h_nxt = h_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode is taken from the next counter value so that the registered
  // pix_req and pipeline stage 0 line up with the counter register itself.
  always_comb begin
    run_nxt   = (state_nxt == RUN);
    st_nxt.hs  = run_nxt && (h_nxt < H_SYNC_END);
    st_nxt.vs  = run_nxt && (v_nxt < V_SYNC_END);
    st_nxt.act = run_nxt && (h_nxt >= H_ACT_BEG) && (h_nxt < H_ACT_END)
                         && (v_nxt >= V_ACT_BEG) && (v_nxt < V_ACT_END);
    st_nxt.fs  = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    st_nxt.x   = 11'(h_nxt) - 11'(H_SYNC + H_BP);
    st_nxt.y   = 10'(v_nxt) - 10'(V_SYNC + V_BP);
  end

  // pipe[k] describes the position whose pix_req went out k clocks ago;
  // pipe[FETCH_LAT] is the one whose data is on pix_data this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_req <= 1'b0;
      for (int i = 0; i <= FETCH_LAT; i++) pipe[i] <= '0;
    end else begin
      pix_req <= st_nxt.act;
      pipe[0] <= st_nxt;
      for (int i = 1; i <= FETCH_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsd         <= 1'b1;
      vsd         <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      hsd         <= ~pipe[FETCH_LAT].hs;
      vsd         <= ~pipe[FETCH_LAT].vs;
      de          <= pipe[FETCH_LAT].act;
      frame_start <= pipe[FETCH_LAT].fs;
      x           <= pipe[FETCH_LAT].act ? pipe[FETCH_LAT].x : 11'd0;
      y           <= pipe[FETCH_LAT].act ? pipe[FETCH_LAT].y : 10'd0;
      if (!pipe[FETCH_LAT].act) rgb <= '0;
      else if (pix_valid)       rgb <= pix_data;
      else                      rgb <= bg_color;
      underflow <= (pipe[FETCH_LAT].act && !pix_valid) ||
                   (underflow && !clr_underflow);
    end
  end

endmodule

// File: doc/mtl_timing_ctrl.md
# mtl_timing_ctrl

Timing controller and pixel-fetch scheduler for the 800x480 MTL panel. It sits between the frame-buffer read path and the `MTL_R/G/B`, `MTL_HSD`, `MTL_VSD` pins, in the `video_clk` domain. It generates panel sync and data-enable, and issues pixel read strobes to the upstream buffer a fixed latency ahead of the active pixel. It substitutes a background colour and flags underflow whenever upstream data is late.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 210: horizontal front porch, clocks
- `H_SYNC`, 30: horizontal sync width, clocks
- `H_BP`, 16: horizontal back porch, clocks (H_TOTAL = 1056)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 22: vertical front porch, lines
- `V_SYNC`, 13: vertical sync width, lines
- `V_BP`, 10: vertical back porch, lines (V_TOTAL = 525)
- `FETCH_LAT`, 2: clocks from `pix_req` to `pix_data`/`pix_valid`; legal range 1..8

Ports:
- `clk`, in, 1: pixel clock (`video_clk`, 33 MHz)
- `reset`, in, 1: asynchronous, active-high
- `enable`, in, 1: run request; sampled every clock
- `bg_color`, in, 24: {R,G,B} substituted on underflow
- `clr_underflow`, in, 1: clears `underflow`
- `pix_req`, out, 1: one-cycle read strobe per active pixel
- `pix_data`, in, 24: {R,G,B} returned by upstream
- `pix_valid`, in, 1: qualifies `pix_data`
- `hsd`, out, 1: horizontal sync, active-low
- `vsd`, out, 1: vertical sync, active-low
- `de`, out, 1: data enable, active-high
- `rgb`, out, 24: pixel to panel, {R,G,B}
- `x`, out, 11: active column 0..799, aligned with `de`
- `y`, out, 10: active row 0..479, aligned with `de`
- `frame_start`, out, 1: one-cycle pulse aligned with the first `hsd`/`vsd` low of a frame
- `underflow`, out, 1: sticky late-data flag

## Operation
- State machine: IDLE, RUN.
  - IDLE: `h_cnt` = `v_cnt` = 0, no `pix_req`. If `enable` = 1, go to RUN. The first RUN cycle has counters at (0,0).
  - RUN: `h_cnt` counts 0..H_TOTAL-1 and wraps, incrementing `v_cnt`. `v_cnt` counts 0..V_TOTAL-1.
  - At the last position (H_TOTAL-1, V_TOTAL-1), if `enable` = 0, go to IDLE. Otherwise wrap to (0,0).
  - Dropping `enable` mid-frame therefore completes the current frame; the block never stops mid-frame.
- Region decode, at counter stage:
  - Horizontal sync when `h_cnt` < H_SYNC.
  - Horizontal active when H_SYNC+H_BP ≤ `h_cnt` < H_SYNC+H_BP+H_ACTIVE.
  - Vertical sync and vertical active are decoded the same way on `v_cnt`.
  - `pix_req` = horizontal active AND vertical active AND RUN.
- Pipeline: sync, active, x, y and frame-start bits pass through a (FETCH_LAT+1)-deep shift register so they align with the returned pixel.
- At expected-data stage FETCH_LAT:
  - If `pix_valid` = 1, register `pix_data`.
  - Else register `bg_color` and set `underflow`.
  - `pix_valid` outside expected slots is ignored.
- Output values:
  - `rgb` = 0 whenever `de` = 0.
  - `x` and `y` = 0 whenever `de` = 0.
- `underflow`: set and clear in the same cycle means set wins. Cleared only by `clr_underflow` or `reset`.
- Arithmetic: counters are unsigned and sized for H_TOTAL/V_TOTAL. `x` = `h_cnt` - (H_SYNC+H_BP), computed at counter stage and truncated to 11 bits. `y` is computed the same way from `v_cnt`.

## Timing
- Reset values: state IDLE, counters 0, `hsd` = 1, `vsd` = 1, `de` = 0, `rgb` = 0, `pix_req` = 0, `x` = 0, `y` = 0, `frame_start` = 0, `underflow` = 0. The shift register is cleared to inactive values.
- All outputs are registered.
- `pix_req` appears 1 clock after its counter position.
- Latency from `pix_req` to the corresponding `de`/`rgb` is FETCH_LAT+1 clocks, i.e. 3 with defaults.
- `enable` sampled high at cycle 0 gives the first RUN cycle at 1, with `hsd`/`vsd`/`frame_start` at 1+FETCH_LAT+1 = 4.
- The first `pix_req` is at cycle 24335 (1 + 23·1056 + 46). The first `de` is at 24338.
- Per line: 800 `pix_req`/`de` cycles and 30 `hsd`-low cycles. Per frame: 13 lines with `vsd` low.
- Upstream must sustain 1 pixel/clock for 800 consecutive clocks.
- Asynchronous `reset` mid-frame: all outputs take reset values immediately. Restart requires `enable` to be sampled high.

## Test plan
- Reset, then `enable` = 1 with an ideal source (`pix_valid` = 1, `pix_data` = {x[7:0], y[7:0], 8'hA5}, latency 2) -> `frame_start` at cycle 4; first `de` at 24338 with `rgb` = 0x0000A5; 800 `de` per line; 1056-clock line and 554400-clock frame period.
- Sync geometry -> `hsd` low exactly 30 clocks per line; `vsd` low for 13·1056 clocks; `de` never high during any sync or porch.
- Drop `pix_valid` for 5 pixels at (100,200) with `bg_color` = 0xFF0000 -> those 5 `rgb` = 0xFF0000 at x = 100..104; `underflow` = 1 and stays set; `clr_underflow` pulse -> 0; set and clear in the same cycle -> 1.
- Deassert `enable` at line 240 -> frame completes; no further `pix_req` or `frame_start`; `hsd` = `vsd` = 1; re-enable -> new `frame_start` 4 cycles later.
- Assert `reset` at pixel (400,100) -> same cycle: `de` = 0, `hsd` = `vsd` = 1, `rgb` = 0; the block stays IDLE until `enable` is sampled.
- FETCH_LAT = 5 build -> `pix_req`-to-`de` latency 6; data still aligned; no spurious underflow.
